// File: rtl/loop_ctl_pkg.sv
// Shared types and default widths for the loop-control stage.
// Optional iteration counter: LOOP_CTL_ITER_CNT_EN.
package loop_ctl_pkg;

  localparam int LC_WIDTH = 16;
  localparam int II_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/loop_ii_counter.sv
// Initiation-interval pacing counter; emits op in the last
// unstalled cycle of each II window. Held at zero while clear.
module loop_ii_counter
  import loop_ctl_pkg::*;
#(
  parameter int iiwidth = II_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               stall,
  input  logic [iiwidth-1:0] ii_q,
  output logic               op
);

  logic [iiwidth-1:0] ii_cnt;
  logic               last;

  assign last = (ii_cnt == ii_q - iiwidth'(1));
  assign op   = last & ~stall & ~clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ii_cnt <= '0;
    end else if (!stall) begin
      ii_cnt <= last ? '0 : ii_cnt + iiwidth'(1);
    end
  end

endmodule

// File: rtl/loop_ctl.sv
// Loop-control stage around brf: owns LC, paces ops at II.
// Optional iter_cnt output when LOOP_CTL_ITER_CNT_EN is defined.
module loop_ctl
  import loop_ctl_pkg::*;
#(
  parameter int lcwidth = LC_WIDTH,
  parameter int iiwidth = II_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [lcwidth-1:0] lc_init,
  input  logic [iiwidth-1:0] ii,
  input  logic               stall,
  output logic               op,
  output logic               running,
  output logic [lcwidth-1:0] lc,
  input  logic [lcwidth-1:0] lc_out,
  input  logic               lc_enable,
  input  logic               p,
  input  logic               p_enable,
  output logic               busy,
  output logic               done
`ifdef LOOP_CTL_ITER_CNT_EN
  ,
  output logic [lcwidth:0]   iter_cnt
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic [iiwidth-1:0] ii_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (p_enable && !p) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign busy    = running | done;

  // LC write-back still lands in the exit cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lc      <= '0;
      ii_q    <= iiwidth'(1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        lc   <= lc_init;
        ii_q <= (ii == '0) ? iiwidth'(1) : ii;
      end else if (running && lc_enable) begin
        lc <= lc_out;
      end
    end
  end

  loop_ii_counter #(
    .iiwidth(iiwidth)
  ) u_ii (
    .clk  (clk),
    .reset(reset),
    .clear(~running),
    .stall(stall),
    .ii_q (ii_q),
    .op   (op)
  );

`ifdef LOOP_CTL_ITER_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      iter_cnt <= '0;
    end else if (op && (iter_cnt != '1)) begin
      iter_cnt <= iter_cnt + (lcwidth+1)'(1);
    end
  end
`endif

endmodule

// File: doc/loop_ctl.md
Name: loop_ctl

Overview:
- Loop-control stage that sits directly around the brf macrocell in the same loop.
- Owns the loop-counter (LC) register and feeds brf its lc, op and running inputs.
- Consumes brf's lc_out, lc_enable, p and p_enable to write back the LC and detect loop exit.
- Paces iterations at a programmable initiation interval (II) and reports busy/done to the surrounding controller.

Parameters:
- lcwidth, 16: LC width; must match brf lcwidth.
- iiwidth, 8: width of the II input and the internal II counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a loop; sampled only in IDLE.
- lc_init  in  lcwidth  initial LC (remaining trip count minus 1), captured on accepted start.
- ii  in  iiwidth  initiation interval, captured on accepted start; 0 treated as 1.
- stall  in  1  freezes iteration pacing while high.
- op  out  1  to brf.op; one-cycle pulse in the last cycle of each II window.
- running  out  1  to brf.running; high in RUN.
- lc  out  lcwidth  to brf.lc; current LC register.
- lc_out  in  lcwidth  from brf.
- lc_enable  in  1  from brf.
- p  in  1  from brf; continue predicate.
- p_enable  in  1  from brf; predicate valid.
- busy  out  1  high in RUN or DONE.
- done  out  1  one-cycle pulse after the loop exits.

Behaviour:
- Reset values: state=IDLE, lc=0, ii_q=1, ii_cnt=0, op=0, running=0, busy=0, done=0.
- FSM states:
  - IDLE: start=1 loads lc<=lc_init, ii_q<=max(ii,1), ii_cnt<=0, and moves to RUN.
  - RUN: op = (ii_cnt==ii_q-1) & ~stall, combinational from registers and stall.
    - If ~stall: ii_cnt wraps to 0 when op=1, otherwise increments.
    - If stall: ii_cnt holds.
    - lc_enable=1 loads lc<=lc_out.
    - p_enable=1 and p=0 moves to DONE; LC is still written back that cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - start accepted at edge t0; RUN from t0+1.
  - First op at cycle t0+ii_q; subsequent ops every ii_q cycles, each extended by stalled cycles.
- Trip count: lc_init=N produces exactly N+1 op pulses; lc reads N, N-1, ..., 0 at the successive ops.
- Boundaries:
  - lc_init=0: one op, then DONE.
  - ii=1: op every non-stalled cycle.
  - start while busy: ignored; lc_init and ii are not re-sampled.
  - p_enable or lc_enable outside RUN: ignored, lc unchanged.
  - stall in the op cycle: op suppressed and deferred until stall falls.
  - reset mid-loop: immediate return to reset values on the next edge; no done pulse.
- Width: lc holds lcwidth bits; no wrap is possible because brf only decrements when lc>0.

Optional Feature:
- Macro: LOOP_CTL_ITER_CNT_EN.
- Defined:
  - Extra output iter_cnt (out, lcwidth+1), cleared on accepted start and on reset.
  - Increments on each op, saturating at all-ones.
  - Holds its final value in IDLE until the next start.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package loop_ctl_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default width constants LC_WIDTH=16 and II_WIDTH=8.
- One sub-module, loop_ii_counter:
  - inputs: clk, reset, clear, stall, ii_q;
  - output: op pulse;
  - owns ii_cnt and its wrap logic.
- LC register, FSM and done logic stay in loop_ctl.

Test Plan:
1. lc_init=2, ii=3, start at t0, no stall -> op at t0+3, t0+6, t0+9 with lc=2,1,0; done at t0+10; IDLE at t0+11; 3 ops total.
2. lc_init=0, ii=1 -> single op at t0+1 with lc=0; done at t0+2.
3. lc_init=3, ii=2, stall high for 2 cycles covering the second op slot -> that op delayed by 2 cycles; 4 ops total; lc sequence 3,2,1,0.
4. Reset asserted at t0+4 during an lc_init=5, ii=2 loop -> next cycle lc=0, running=0, busy=0; no done pulse; later ops absent.
5. start pulsed again during RUN with lc_init=7 -> ignored; original trip count (lc_init=2) completes with 3 ops.
6. With LOOP_CTL_ITER_CNT_EN, lc_init=4, ii=2 -> iter_cnt=5 after done; cleared to 0 on the next start.
